// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//
// Sequencing controller for the two-digit timer display. Debounced
// start/pause/clear buttons start, pause, resume or clear an up or down count
// in the range 0..MAX_VAL. An internal prescaler advances the count once
// every TICK_DIV clock cycles. The count goes to the seven-segment driver.
//
// Parameters
//   TICK_DIV  clk cycles per count step (>= 2)
//   MAX_VAL   up-count terminal value and clamp for the preset (<= 99)
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  synchronous active-low reset
//   btn_start  in   1  start / resume (debounced level)
//   btn_pause  in   1  pause / resume toggle (debounced level)
//   btn_clear  in   1  clear to idle (debounced level)
//   dir        in   1  0 = count up from 0, 1 = count down from preset
//   load_val   in   7  down-count preset (values above MAX_VAL clamp)
//   num        out  7  current count (registered)
//   running    out  1  high while counting (registered)
//   done       out  1  high once the terminal value is reached (registered)
//   tick       out  1  one-cycle pulse on each count step (registered)
// ---------------------------------------------------------------------------
module timer_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned MAX_VAL  = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       dir,
  input  logic [6:0] load_val,
  output logic [6:0] num,
  output logic       running,
  output logic       done,
  output logic       tick
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [6:0] MAX_V = 7'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  // One command per cycle after priority resolution
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_START,
    CMD_PAUSE,
    CMD_CLEAR
  } cmd_t;

  state_t              state_q, state_d;
  logic [6:0]          num_q, num_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                dir_q, dir_d;
  logic                tick_d;
  logic                start_q, pause_q, clear_q;

  logic                start_rise, pause_rise, clear_rise;
  cmd_t                cmd;
  logic [6:0]          preset;
  logic [6:0]          term_sel;
  logic [6:0]          term_run;
  logic [6:0]          stepped;
  logic                wrap;

  // Rising-edge detection; held levels do nothing
  assign start_rise = btn_start & ~start_q;
  assign pause_rise = btn_pause & ~pause_q;
  assign clear_rise = btn_clear & ~clear_q;

  // Clear beats pause beats start
  always_comb begin
    cmd = CMD_NONE;
    if (clear_rise) begin
      cmd = CMD_CLEAR;
    end else if (pause_rise) begin
      cmd = CMD_PAUSE;
    end else if (start_rise) begin
      cmd = CMD_START;
    end
  end

  // Preset and terminal value follow the live dir input; they only matter
  // where a new run is being set up (idle display, start, start from done).
  always_comb begin
    preset = 7'd0;
    if (dir) begin
      preset = (load_val > MAX_V) ? MAX_V : load_val;
    end
    term_sel = dir ? 7'd0 : MAX_V;
  end

  // Inside a run the latched direction decides step sign and terminal value,
  // so the count never passes the terminal and never wraps.
  assign term_run = dir_q ? 7'd0 : MAX_V;
  assign stepped  = dir_q ? (num_q - 7'd1) : (num_q + 7'd1);
  assign wrap     = (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        num_d   = preset;
        presc_d = '0;
        dir_d   = dir;
        if (cmd == CMD_START) begin
          state_d = (preset == term_sel) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        if (cmd == CMD_CLEAR) begin
          // A step due in this same cycle is dropped
          state_d = ST_IDLE;
          num_d   = preset;
          presc_d = '0;
        end else begin
          if (wrap) begin
            presc_d = '0;
            tick_d  = 1'b1;
            num_d   = stepped;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          // Reaching the terminal wins over a simultaneous pause
          if (wrap && (stepped == term_run)) begin
            state_d = ST_DONE;
          end else if (cmd == CMD_PAUSE) begin
            state_d = ST_PAUSE;
          end
        end
      end

      ST_PAUSE: begin
        // Prescaler keeps its partial period so resume continues it
        if (cmd == CMD_CLEAR) begin
          state_d = ST_IDLE;
          num_d   = preset;
          presc_d = '0;
        end else if ((cmd == CMD_PAUSE) || (cmd == CMD_START)) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (cmd == CMD_CLEAR) begin
          state_d = ST_IDLE;
          num_d   = preset;
          presc_d = '0;
        end else if (cmd == CMD_START) begin
          dir_d   = dir;
          num_d   = preset;
          presc_d = '0;
          state_d = (preset == term_sel) ? ST_DONE : ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
        num_d   = 7'd0;
        presc_d = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      num_q   <= 7'd0;
      presc_q <= '0;
      dir_q   <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      clear_q <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      start_q <= btn_start;
      pause_q <= btn_pause;
      clear_q <= btn_clear;
      running <= (state_d == ST_RUN);
      done    <= (state_d == ST_DONE);
      tick    <= tick_d;
    end
  end

  assign num = num_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
//
// Self-checking bench for timer_ctrl with TICK_DIV=4, MAX_VAL=99. A table of
// hand-derived vectors comes first, then multi-cycle sequences whose
// expectations come from a small behavioural model. Every expected output is
// pushed to a scoreboard queue when the stimulus is driven and popped when
// the DUT outputs are sampled, 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int MAX_VAL  = 99;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_clear;
  logic       dir;
  logic [6:0] load_val;
  logic [6:0] num;
  logic       running;
  logic       done;
  logic       tick;

  always #5 clk = ~clk;

  timer_ctrl #(
    .TICK_DIV (TICK_DIV),
    .MAX_VAL  (MAX_VAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .btn_clear (btn_clear),
    .dir       (dir),
    .load_val  (load_val),
    .num       (num),
    .running   (running),
    .done      (done),
    .tick      (tick)
  );

  typedef struct packed {
    logic [6:0] num;
    logic       running;
    logic       done;
    logic       tick;
  } out_t;

  typedef struct {
    logic       rn;
    logic       s;
    logic       p;
    logic       c;
    logic       d;
    logic [6:0] lv;
    logic [6:0] e_num;
    logic       e_run;
    logic       e_done;
    logic       e_tick;
  } vec_t;

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_PAUSE, M_DONE} m_state_t;

  out_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  m_state_t   m_state = M_IDLE;
  logic [6:0] m_num   = 7'd0;
  int         m_presc = 0;
  logic       m_tick  = 1'b0;
  logic       m_dir   = 1'b0;
  logic       m_s     = 1'b0;
  logic       m_p     = 1'b0;
  logic       m_c     = 1'b0;

  logic       cur_dir = 1'b0;
  logic [6:0] cur_lv  = 7'd0;

  // Behavioural reference: one call per clock edge
  task automatic model_step(input logic rn, input logic s, input logic p,
                            input logic c, input logic d, input logic [6:0] lv);
    logic sr, pr, cr;
    int   pre, trm_in, trm_run, nxt;
    m_tick = 1'b0;
    if (!rn) begin
      m_state = M_IDLE;
      m_num   = 7'd0;
      m_presc = 0;
      m_dir   = 1'b0;
      m_s     = 1'b0;
      m_p     = 1'b0;
      m_c     = 1'b0;
      return;
    end
    cr  = c & ~m_c;
    pr  = p & ~m_p & ~cr;
    sr  = s & ~m_s & ~cr & ~pr;
    m_s = s;
    m_p = p;
    m_c = c;
    pre     = d ? ((int'(lv) > MAX_VAL) ? MAX_VAL : int'(lv)) : 0;
    trm_in  = d ? 0 : MAX_VAL;
    trm_run = m_dir ? 0 : MAX_VAL;
    case (m_state)
      M_IDLE: begin
        m_num   = 7'(pre);
        m_presc = 0;
        m_dir   = d;
        if (sr) m_state = (pre == trm_in) ? M_DONE : M_RUN;
      end
      M_RUN: begin
        if (cr) begin
          m_state = M_IDLE;
          m_num   = 7'(pre);
          m_presc = 0;
        end else if (m_presc == TICK_DIV - 1) begin
          m_presc = 0;
          m_tick  = 1'b1;
          nxt     = m_dir ? int'(m_num) - 1 : int'(m_num) + 1;
          m_num   = 7'(nxt);
          if (nxt == trm_run) m_state = M_DONE;
          else if (pr) m_state = M_PAUSE;
        end else begin
          m_presc = m_presc + 1;
          if (pr) m_state = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (cr) begin
          m_state = M_IDLE;
          m_num   = 7'(pre);
          m_presc = 0;
        end else if (pr || sr) begin
          m_state = M_RUN;
        end
      end
      M_DONE: begin
        if (cr) begin
          m_state = M_IDLE;
          m_num   = 7'(pre);
          m_presc = 0;
        end else if (sr) begin
          m_dir   = d;
          m_num   = 7'(pre);
          m_presc = 0;
          m_state = (pre == trm_in) ? M_DONE : M_RUN;
        end
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic checkOutput(input string name);
    out_t e;
    out_t a;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    a = {num, running, done, tick};
    if (a !== e) begin
      tests_failed++;
      $display("[TB] FAIL %s: got num=%0d running=%b done=%b tick=%b, expected num=%0d running=%b done=%b tick=%b",
               name, a.num, a.running, a.done, a.tick, e.num, e.running, e.done, e.tick);
    end
  endtask

  // Drive one cycle; expectation comes from the table when use_tbl is set,
  // otherwise from the model. The model always advances to stay in step.
  task automatic applyStimulus(input logic rn, input logic s, input logic p,
                               input logic c, input logic d, input logic [6:0] lv,
                               input bit use_tbl, input out_t tbl_exp,
                               input string name);
    @(negedge clk);
    rst_n     = rn;
    btn_start = s;
    btn_pause = p;
    btn_clear = c;
    dir       = d;
    load_val  = lv;
    model_step(rn, s, p, c, d, lv);
    if (use_tbl) exp_q.push_back(tbl_exp);
    else exp_q.push_back({m_num, (m_state == M_RUN), (m_state == M_DONE), m_tick});
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  task automatic step(input logic s, input logic p, input logic c, input string name);
    applyStimulus(1'b1, s, p, c, cur_dir, cur_lv, 1'b0, '0, name);
  endtask

  task automatic check_val(input string name, input int act, input int expv);
    tests_run++;
    if (act != expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Time limit so a stuck run still ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[22];
    int   ticks;
    int   lat;
    bit   found;

    //            rn   s    p    c    d    lv        num    run  done tick
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,7'd0,   7'd0,  1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,7'd3,   7'd3,  1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,7'd120, 7'd99, 1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,7'd3,   7'd3,  1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,7'd3,   7'd3,  1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,7'd3,   7'd3,  1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd3,  1'b1,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd3,  1'b1,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd2,  1'b1,1'b0,1'b1};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd2,  1'b1,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd2,  1'b1,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd2,  1'b1,1'b0,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd1,  1'b1,1'b0,1'b1};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd1,  1'b1,1'b0,1'b0};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd1,  1'b1,1'b0,1'b0};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd1,  1'b1,1'b0,1'b0};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd0,  1'b0,1'b1,1'b1};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0,7'd3,   7'd0,  1'b0,1'b1,1'b0};
    tbl[18] = '{1'b1,1'b1,1'b0,1'b0,1'b1,7'd5,   7'd5,  1'b1,1'b0,1'b0};
    tbl[19] = '{1'b1,1'b0,1'b0,1'b0,1'b1,7'd5,   7'd5,  1'b1,1'b0,1'b0};
    tbl[20] = '{1'b1,1'b0,1'b0,1'b1,1'b1,7'd5,   7'd5,  1'b0,1'b0,1'b0};
    tbl[21] = '{1'b1,1'b0,1'b0,1'b0,1'b1,7'd5,   7'd5,  1'b0,1'b0,1'b0};

    rst_n     = 1'b0;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    btn_clear = 1'b0;
    dir       = 1'b0;
    load_val  = 7'd0;

    for (int i = 0; i < 22; i++) begin
      applyStimulus(tbl[i].rn, tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].d, tbl[i].lv, 1'b1,
                    {tbl[i].e_num, tbl[i].e_run, tbl[i].e_done, tbl[i].e_tick},
                    $sformatf("vec%0d", i));
    end

    // Full up-count to MAX_VAL
    cur_dir = 1'b0;
    cur_lv  = 7'd0;
    step(1'b0, 1'b0, 1'b0, "up_idle");
    step(1'b1, 1'b0, 1'b0, "up_start");
    ticks = 0;
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'b0, 1'b0, $sformatf("up_cyc%0d", i));
      if (tick) ticks++;
    end
    check_val("up_tick_count", ticks, 99);
    check_val("up_hold_num", int'(num), 99);
    check_val("up_done_flag", int'(done), 1);

    // Pause two cycles into a period, hold the button, resume
    step(1'b0, 1'b0, 1'b1, "pz_clear");
    step(1'b0, 1'b0, 1'b0, "pz_rel");
    step(1'b1, 1'b0, 1'b0, "pz_start");
    step(1'b0, 1'b0, 1'b0, "pz_run1");
    step(1'b0, 1'b1, 1'b0, "pz_pause");
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, $sformatf("pz_hold%0d", i));
    check_val("pz_single_toggle", int'(running), 0);
    step(1'b0, 1'b0, 1'b0, "pz_release");
    step(1'b0, 1'b1, 1'b0, "pz_resume");
    lat   = 0;
    found = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0, $sformatf("pz_wait%0d", k));
      if (tick && !found) begin
        lat   = k;
        found = 1'b1;
        break;
      end
    end
    check_val("pz_resume_latency", lat, 2);

    // All three buttons together during RUN
    step(1'b0, 1'b0, 1'b1, "pr_clear");
    step(1'b0, 1'b0, 1'b0, "pr_rel");
    step(1'b1, 1'b0, 1'b0, "pr_start");
    step(1'b0, 1'b0, 1'b0, "pr_run1");
    step(1'b0, 1'b0, 1'b0, "pr_run2");
    step(1'b1, 1'b1, 1'b1, "pr_all3");
    check_val("pr_all3_running", int'(running), 0);
    check_val("pr_all3_num", int'(num), 0);

    // Pause coinciding with the prescaler wrap
    step(1'b0, 1'b0, 1'b0, "pw_rel");
    step(1'b1, 1'b0, 1'b0, "pw_start");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, $sformatf("pw_run%0d", i));
    step(1'b0, 1'b1, 1'b0, "pw_pause_wrap");
    check_val("pw_num_stepped", int'(num), 1);
    check_val("pw_paused", int'(running), 0);

    // Clear coinciding with the wrap drops the step
    step(1'b0, 1'b0, 1'b0, "cw_rel");
    step(1'b0, 1'b1, 1'b0, "cw_resume");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, $sformatf("cw_run%0d", i));
    step(1'b0, 1'b0, 1'b1, "cw_clear_wrap");
    check_val("cw_no_tick", int'(tick), 0);
    check_val("cw_num_preset", int'(num), 0);

    // Down-count from 0 is done immediately, then start from DONE with preset 5
    cur_dir = 1'b1;
    cur_lv  = 7'd0;
    step(1'b0, 1'b0, 1'b0, "z_rel");
    step(1'b1, 1'b0, 1'b0, "z_start");
    check_val("z_done", int'(done), 1);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, $sformatf("z_hold%0d", i));
      if (tick) ticks++;
    end
    check_val("z_no_tick", ticks, 0);
    cur_lv = 7'd5;
    step(1'b1, 1'b0, 1'b0, "z_restart");
    check_val("z_restart_num", int'(num), 5);
    check_val("z_restart_running", int'(running), 1);

    // Reset mid-run at 42, then confirm the prescaler restarts from 0
    cur_dir = 1'b0;
    cur_lv  = 7'd0;
    step(1'b0, 1'b0, 1'b1, "r_clear");
    step(1'b0, 1'b0, 1'b0, "r_rel");
    step(1'b1, 1'b0, 1'b0, "r_start");
    for (int i = 0; i < 300; i++) begin
      if (num == 7'd42) break;
      step(1'b0, 1'b0, 1'b0, $sformatf("r_run%0d", i));
    end
    check_val("r_reached_42", int'(num), 42);
    step(1'b0, 1'b0, 1'b0, "r_pre");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, cur_dir, cur_lv, 1'b0, '0, "r_reset");
    check_val("r_reset_num", int'(num), 0);
    step(1'b0, 1'b0, 1'b0, "r_idle");
    step(1'b1, 1'b0, 1'b0, "r_restart");
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0, 1'b0, $sformatf("r_wait%0d", k));
      if (tick) begin
        lat = k;
        break;
      end
    end
    check_val("r_first_tick_latency", lat, TICK_DIV);

    // Random button activity checked against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) cur_dir = ~cur_dir;
      if ($urandom_range(0, 9) == 0) cur_lv = 7'($urandom_range(0, 127));
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 29) == 0), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the two-digit timer display. It turns debounced start/pause/clear buttons into an up or down count in the range 0..MAX_VAL, advanced by an internal prescaler tick. It drives the 7-bit `num` input of the downstream seven-segment driver, which splits the value into two decimal digits. It also reports run/done status for LEDs.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per count step (1 s at 50 MHz); must be ≥2.
- `MAX_VAL`, 99: terminal value for up-count and clamp for preset; must be ≤99.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `btn_start`  in  1  start/resume; debounced, clk-synchronous level.
- `btn_pause`  in  1  pause/resume toggle; debounced level.
- `btn_clear`  in  1  clear to idle; debounced level.
- `dir`  in  1  0 = count up from 0, 1 = count down from preset.
- `load_val`  in  7  down-count preset.
- `num`  out  7  current count to the segment driver; registered.
- `running`  out  1  high while in RUN; registered.
- `done`  out  1  high while in DONE; registered.
- `tick`  out  1  one-cycle pulse on every count step; registered.

## Operation
- Buttons are edge-detected. Each has a 1-bit history register. `x_rise = btn_x & ~btn_x_q`. Only rises act; held levels are ignored.
- Command priority within one cycle: clear > pause > start.
- `preset = dir ? min(load_val, MAX_VAL) : 0`. `load_val` values 100..127 clamp to MAX_VAL.
- Terminal value: `dir=0` uses MAX_VAL; `dir=1` uses 0.
- FSM states are IDLE, RUN, PAUSE and DONE. Reset enters IDLE.
- IDLE:
  - `num` <= preset every cycle, so the preset is shown live.
  - Prescaler is held at 0.
  - start_rise: go to RUN. If preset already equals the terminal value, go to DONE instead.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - At wrap, `tick` pulses and `num` steps by ±1 according to `dir`.
  - If the stepped value equals the terminal value, go to DONE in the same edge.
  - clear_rise: go to IDLE.
  - pause_rise: go to PAUSE.
- PAUSE:
  - Prescaler and `num` are frozen; the prescaler is not reset.
  - start_rise or pause_rise: go to RUN, continuing the partial period.
  - clear_rise: go to IDLE.
- DONE:
  - `num` holds the terminal value.
  - clear_rise: go to IDLE.
  - start_rise: reload `num` with preset, clear the prescaler, go to RUN. If preset equals the terminal value, stay in DONE.
- `dir` is sampled only in IDLE and at a start from DONE. The direction is latched into an internal `dir_q` for the whole run. Changing `dir` mid-run has no effect.
- Arithmetic is 7-bit. Because the run stops at the terminal value, `num` never wraps and is always in 0..MAX_VAL.
- The prescaler width is `$clog2(TICK_DIV)`.

## Timing
- Reset (rst_n=0 at a rising edge) produces: state IDLE, `num`=0, `running`=0, `done`=0, `tick`=0, prescaler=0, button history=0.
- Reset takes effect mid-run; nothing is retained.
- Command latency: a button sampled high at edge k, after being low at k-1, changes the state at edge k. `running`/`done` reflect the new state after edge k.
- Step latency: the first `tick` comes TICK_DIV cycles after the RUN entry edge. Subsequent ticks are every TICK_DIV cycles of RUN time; PAUSE cycles are excluded.
- `tick` and the `num` update occur at the same edge.
- Pause in the same cycle as the prescaler wrap: the step is applied, then the FSM goes to PAUSE with the prescaler at 0.
- Clear in the same cycle as the wrap: the FSM goes to IDLE and the step is discarded.
- Final step to the terminal value: `done` rises at the same edge that `num` reaches terminal. No further `tick` is issued.
- start_rise while in RUN has no effect.

## Test plan
- Reset, then up-count with TICK_DIV=4, dir=0, start pulse → `running`=1; `num` steps 1,2,3 every 4 cycles with a `tick` pulse each step; at 99, `done`=1, `running`=0, and `num` holds 99.
- Down-count: dir=1, load_val=3. In IDLE `num`=3. Start → steps 2,1,0 → DONE with `num`=0. Repeat with load_val=120 → IDLE shows 99.
- Pause precision: TICK_DIV=4. Pause 2 cycles into a period, hold 10 cycles, resume → next `tick` exactly 2 RUN cycles later. Holding `btn_pause` high for 10 cycles produces a single toggle.
- Priority: start, pause and clear all rise in one cycle during RUN → IDLE, `num`=preset. Pause and wrap coincide → `num` stepped, state PAUSE.
- Boundaries: dir=1, load_val=0, start → DONE next edge with no `tick`. Start from DONE with load_val=5 → `num`=5, RUN. Change `dir` mid-run → count direction unchanged.
- Reset mid-run at `num`=42 with rst_n=0 for one edge → `num`=0, IDLE, all flags 0. Next start restarts the prescaler from 0.
